vid_pixel_pipe: RTL
===================

# vid_pixel_pipe

Parametrised pixel serializer for the video path: accepts packed graphics words from the VRAM fetch logic through a valid/ready FIFO, shifts them out MSB-first at a programmable bits-per-pixel (1/2/4), and maps each pixel index through a writable palette to the final IRGB-style colour. It sits between the CRTC-driven VRAM fetch sequencer and the attribute/DAC stage. It generalises the fixed-width CGA/Tandy pixel mux with buffering, runtime depth selection, underflow detection and a programmable palette.

## Interface
- DATA_W, 8: input word width; must be a multiple of 4.
- FIFO_DEPTH, 4: word FIFO depth; power of two, ≥2.
- PAL_W, 4: palette entry / output colour width.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_ce  in  1  pixel clock enable; one pixel is consumed per asserted cycle
- bpp_mode  in  2  0=1bpp, 1=2bpp, 2=4bpp, 3=reserved (treated as 4bpp)
- in_valid  in  1  fetch word valid
- in_ready  out  1  FIFO not full
- in_data  in  DATA_W  packed pixel word, leftmost pixel in MSBs
- display_enable  in  1  active display area
- border_color  in  PAL_W  colour output outside active area and on underflow
- pal_we  in  1  palette write strobe
- pal_addr  in  4  palette entry index
- pal_data  in  PAL_W  palette write data
- video_out  out  PAL_W  registered pixel colour
- underflow  out  1  one-cycle pulse: pixel requested with shifter and FIFO empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered

## Operation
- FIFO: push on in_valid && in_ready; in_ready = !full (combinational). Pop only by the shifter. No bypass: a word pushed in cycle N is poppable from cycle N+1.
- Shifter: data register, remaining-pixel count cnt, latched shift width bw (1/2/4). States: EMPTY (cnt==0), SHIFT (cnt>0).
- At each pix_ce with display_enable=1:
  - EMPTY, FIFO non-empty: pop; bw latched from bpp_mode; pixel = top bw bits of popped word; shifter = word << bw; cnt = DATA_W/bw − 1.
  - SHIFT: pixel = top bw bits of shifter; shift left by bw; cnt decrements.
  - EMPTY, FIFO empty: video_out = border_color; underflow pulses; nothing consumed.
- pix_ce with display_enable=0: video_out = border_color; cnt cleared (partial word discarded, next line starts word-aligned); FIFO untouched.
- bpp_mode changes take effect only at the next word load.
- Pixel index zero-extended to 4 bits, looked up in 16-entry palette; result registered into video_out.
- Palette write synchronous on pal_we; a lookup of the same entry in the same cycle returns the old value.
- No pix_ce: video_out, shifter and cnt hold.

## Timing
- video_out valid the cycle after the consuming pix_ce (1-cycle latency).
- underflow asserted in the cycle after the starving pix_ce, for exactly one cycle.
- Reset (any time, including mid-word): FIFO pointers and fifo_level 0, in_ready 1, cnt 0, video_out 0, underflow 0, palette entry i = i (identity, truncated/zero-extended to PAL_W).
- Full FIFO with simultaneous pop: in_ready remains 0 that cycle.
- Push to empty FIFO in same cycle as EMPTY pix_ce: underflow, word retained.

## Configuration
- VID_PIXEL_PIPE_PALETTE_EN defined: palette RAM, pal_* ports functional.
- Undefined: no palette storage; video_out = pixel index zero-extended/truncated to PAL_W; pal_* ports present but ignored; reset values unchanged otherwise.

## Structure
- Package vid_pixel_pkg: bpp_mode encoding enum, bpp_mode→bw function, identity-palette default constant.
- Sub-module vid_pixel_fifo (parametrised synchronous FIFO, level output); shifter, palette and output register in the top.

## Test plan
- 1bpp, push 8'hA5, pix_ce every cycle -> video_out sequence 1,0,1,0,0,1,0,1, then border + underflow pulse.
- 2bpp, push 8'h1B -> indices 0,1,2,3; with palette entry 2 written to 4'hC beforehand -> 0,1,C,3.
- 4bpp, push 8'h7E, 8'h12 back to back -> 7,E,1,2; fifo_level 2→1→0; in_ready high throughout.
- Fill FIFO with 4 words, no pix_ce -> in_ready 0, fifo_level 4; single pix_ce -> in_ready 1 next cycle.
- Drop display_enable after 3 pixels of a 1bpp word -> border output, cnt cleared; next active pix_ce starts from MSB of next FIFO word.
- Assert reset mid-word at 2bpp -> video_out 0, fifo_level 0, palette identity; without VID_PIXEL_PIPE_PALETTE_EN palette writes have no effect.

Source files
------------

// File: rtl/vid_pixel_pkg.sv
// Shared types and helpers for the pixel serializer: bits-per-pixel encoding,
// shifter state, bits-per-pixel to shift width mapping, identity palette.
package vid_pixel_pkg;

   typedef enum logic [1:0] {
      BPP_1    = 2'd0,
      BPP_2    = 2'd1,
      BPP_4    = 2'd2,
      BPP_RSVD = 2'd3
   } bpp_mode_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_SHIFT = 1'b1
   } shift_state_e;

   // Entry i holds i; the top module truncates or zero-extends to PAL_W.
   localparam logic [15:0][3:0] PAL_IDENTITY = 64'hFEDC_BA98_7654_3210;

   // Shift width in bits for a bits-per-pixel mode; reserved behaves as 4bpp.
   function automatic logic [2:0] bpp_to_bw(input logic [1:0] mode);
      case (bpp_mode_e'(mode))
         BPP_1:   return 3'd1;
         BPP_2:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Leftmost pixel of a word given its top four bits, zero-extended to 4 bits.
   function automatic logic [3:0] pix_sel(input logic [3:0] top4, input logic [2:0] bw);
      case (bw)
         3'd1:    return {3'b000, top4[3]};
         3'd2:    return {2'b00, top4[3:2]};
         default: return top4;
      endcase
   endfunction

endpackage

// File: rtl/vid_pixel_fifo.sv
// Synchronous word FIFO with occupancy output. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module vid_pixel_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        data_i,
   output logic                     ready_o,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        data_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign ready_o = !full;
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign level_o = wr_ptr_q - rd_ptr_q;

   // Pointer update; a push and pop in the same cycle both advance.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Word storage write port.
   // NOTE: storage is not reset; the pointers alone define which words are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/vid_pixel_pipe.sv
// Pixel serializer: buffers fetched words, shifts pixels out MSB-first at
// 1/2/4 bpp on pix_ce, maps each index through a palette into a registered
// colour, and flags starvation with a one-cycle underflow pulse.
// Optional feature macro: VID_PIXEL_PIPE_PALETTE_EN (writable palette RAM);
// when undefined the pixel index drives the colour directly.
module vid_pixel_pipe
   import vid_pixel_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PAL_W      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          pix_ce,
   input  logic [1:0]                    bpp_mode,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          display_enable,
   input  logic [PAL_W-1:0]              border_color,
   input  logic                          pal_we,
   input  logic [3:0]                    pal_addr,
   input  logic [PAL_W-1:0]              pal_data,
   output logic [PAL_W-1:0]              video_out,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CNT_W = $clog2(DATA_W);

   logic              fifo_pop;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;

   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bw_q, bw_d;
   logic [PAL_W-1:0]  video_out_q, video_out_d;
   logic              underflow_q, underflow_d;

   shift_state_e      state;
   logic [2:0]        load_bw;
   logic [3:0]        pix_idx;
   logic [PAL_W-1:0]  pix_color;

   vid_pixel_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (in_valid),
      .data_i  (in_data),
      .ready_o (in_ready),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // Remaining pixels after the first one of a freshly loaded word.
   function automatic logic [CNT_W-1:0] word_pixels_m1(input logic [2:0] bw);
      case (bw)
         3'd1:    return CNT_W'(DATA_W - 1);
         3'd2:    return CNT_W'(DATA_W/2 - 1);
         default: return CNT_W'(DATA_W/4 - 1);
      endcase
   endfunction

   assign state = (cnt_q == '0) ? ST_EMPTY : ST_SHIFT;

   // Candidate pixel index: head of the FIFO word when empty, else shifter MSBs.
   always_comb begin
      load_bw = bpp_to_bw(bpp_mode);
      if (state == ST_EMPTY) pix_idx = pix_sel(fifo_rdata[DATA_W-1 -: 4], load_bw);
      else                   pix_idx = pix_sel(shreg_q[DATA_W-1 -: 4], bw_q);
   end

`ifdef VID_PIXEL_PIPE_PALETTE_EN
   logic [PAL_W-1:0] pal_q [16];

   // Palette RAM, identity on reset; reads see the pre-write contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) pal_q[i] <= PAL_W'(PAL_IDENTITY[i]);
      end else if (pal_we) begin
         pal_q[pal_addr] <= pal_data;
      end
   end

   assign pix_color = pal_q[pix_idx];
`else
   assign pix_color = PAL_W'(pix_idx);

   wire unused_pal = &{1'b0, pal_we, pal_addr, pal_data};
`endif

   // Shifter state register and registered colour output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q     <= '0;
         cnt_q       <= '0;
         bw_q        <= 3'd1;
         video_out_q <= '0;
         underflow_q <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         bw_q        <= bw_d;
         video_out_q <= video_out_d;
         underflow_q <= underflow_d;
      end
   end

   // Next-state: load, shift, starve or blank on each pixel enable.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      bw_d        = bw_q;
      video_out_d = video_out_q;
      underflow_d = 1'b0;
      fifo_pop    = 1'b0;
      if (pix_ce) begin
         if (!display_enable) begin
            // Blanking drops any partial word so the next line starts aligned.
            video_out_d = border_color;
            cnt_d       = '0;
         end else begin
            case (state)
               ST_EMPTY: begin
                  if (!fifo_empty) begin
                     fifo_pop    = 1'b1;
                     bw_d        = load_bw;
                     shreg_d     = fifo_rdata << load_bw;
                     cnt_d       = word_pixels_m1(load_bw);
                     video_out_d = pix_color;
                  end else begin
                     video_out_d = border_color;
                     underflow_d = 1'b1;
                  end
               end
               ST_SHIFT: begin
                  shreg_d     = shreg_q << bw_q;
                  cnt_d       = cnt_q - CNT_W'(1);
                  video_out_d = pix_color;
               end
               default: ;
            endcase
         end
      end
   end

   assign video_out = video_out_q;
   assign underflow = underflow_q;

endmodule
